// File: rtl/acquisition_controller_pkg.sv
// Shared definitions for the acquisition controller: state encodings, status
// byte layout, register map and reset defaults.
package acquisition_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } acq_state_e;

  localparam int STAT_DONE_BIT  = 7;
  localparam int STAT_TRIG_BIT  = 6;
  localparam int STAT_STATE_LSB = 3;

  localparam logic [7:0]  ADDR_PRETRIGGER_DFLT     = 8'h0B;
  localparam logic [7:0]  ADDR_NUM_SAMPLES_DFLT    = 8'h0C;
  localparam logic [15:0] DEFAULT_PRETRIGGER_DFLT  = 16'd128;
  localparam logic [15:0] DEFAULT_NUM_SAMPLES_DFLT = 16'd256;

  function automatic logic [7:0] pack_status(logic done, logic trig, acq_state_e st);
    logic [7:0] b;
    b = 8'h00;
    b[STAT_DONE_BIT] = done;
    b[STAT_TRIG_BIT] = trig;
    b[STAT_STATE_LSB +: 3] = 3'(st);
    return b;
  endfunction

endpackage

// File: rtl/status_tx_reg.sv
// One-byte status frame holding register: latches a byte on request and holds
// it valid until the consumer acknowledges.
module status_tx_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       rqst_i,
  input  logic       ack_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       rdy_o,
  output logic       eof_o
);

  logic [7:0] data_q;
  logic       rdy_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= 8'h00;
      rdy_q  <= 1'b0;
    end else if (rdy_q) begin
      if (ack_i) rdy_q <= 1'b0;
    end else if (rqst_i) begin
      data_q <= data_i;
      rdy_q  <= 1'b1;
    end
  end

  // The frame is a single byte, so every valid byte is also the last one.
  assign data_o = data_q;
  assign rdy_o  = rdy_q;
  assign eof_o  = rdy_q;

endmodule

// File: rtl/acquisition_controller.sv
// Pretrigger/post-trigger capture sequencer with a small register file and a
// status byte readout.
//
// state | meaning
// IDLE  | no capture, waiting for start
// PRE   | collecting P pretrigger samples, trigger ignored
// ARMED | buffer filling, waiting for a qualified trigger sample
// POST  | collecting the remaining N-P post-trigger samples
// DONE  | capture complete, waiting for a new start
module acquisition_controller
  import acquisition_controller_pkg::*;
#(
  parameter int                        REG_DATA_WIDTH      = 16,
  parameter int                        REG_ADDR_WIDTH      = 8,
  parameter logic [REG_ADDR_WIDTH-1:0] ADDR_PRETRIGGER     = ADDR_PRETRIGGER_DFLT,
  parameter logic [REG_ADDR_WIDTH-1:0] ADDR_NUM_SAMPLES    = ADDR_NUM_SAMPLES_DFLT,
  parameter logic [REG_DATA_WIDTH-1:0] DEFAULT_PRETRIGGER  = DEFAULT_PRETRIGGER_DFLT,
  parameter logic [REG_DATA_WIDTH-1:0] DEFAULT_NUM_SAMPLES = DEFAULT_NUM_SAMPLES_DFLT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      sample_tick,
  input  logic                      trigger_event,
  input  logic [REG_ADDR_WIDTH-1:0] register_addr,
  input  logic [REG_DATA_WIDTH-1:0] register_data,
  input  logic                      register_rdy,
  input  logic                      rqst_status,
  output logic                      we,
  output logic [REG_DATA_WIDTH-1:0] num_samples_o,
  output logic [7:0]                status_data,
  output logic                      status_rdy,
  output logic                      status_eof,
  input  logic                      status_ack
);

  localparam logic [REG_DATA_WIDTH-1:0] ONE = REG_DATA_WIDTH'(1);

  logic [REG_DATA_WIDTH-1:0] pretrigger_q, num_samples_q;
  logic [REG_DATA_WIDTH-1:0] n_start_d, p_start_d;
  logic [REG_DATA_WIDTH-1:0] pre_rem_q, post_rem_q, post_len_q, num_work_q;
  acq_state_e                state_q;
  logic                      we_q, triggered_q;
  logic [7:0]                status_byte_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pretrigger_q  <= DEFAULT_PRETRIGGER;
      num_samples_q <= DEFAULT_NUM_SAMPLES;
    end else if (register_rdy) begin
      if (register_addr == ADDR_PRETRIGGER)  pretrigger_q  <= register_data;
      if (register_addr == ADDR_NUM_SAMPLES) num_samples_q <= register_data;
    end
  end

  // Working copy: at least one sample, and at least one post-trigger sample.
  always_comb begin
    n_start_d = (num_samples_q == '0) ? ONE : num_samples_q;
    p_start_d = (pretrigger_q >= n_start_d) ? (n_start_d - ONE) : pretrigger_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      triggered_q <= 1'b0;
      pre_rem_q   <= '0;
      post_rem_q  <= '0;
      post_len_q  <= '0;
      num_work_q  <= DEFAULT_NUM_SAMPLES;
    end else if (stop) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      triggered_q <= 1'b0;
      pre_rem_q   <= '0;
      post_rem_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q     <= ST_PRE;
            we_q        <= 1'b1;
            triggered_q <= 1'b0;
            pre_rem_q   <= p_start_d;
            post_rem_q  <= '0;
            post_len_q  <= n_start_d - p_start_d;
            num_work_q  <= n_start_d;
          end
        end
        ST_PRE: begin
          if (pre_rem_q == '0) begin
            state_q <= ST_ARMED;
          end else if (sample_tick) begin
            pre_rem_q <= pre_rem_q - ONE;
            if (pre_rem_q == ONE) state_q <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          // The trigger sample is post-sample 1; a single-sample post window
          // therefore completes on the trigger tick itself.
          if (sample_tick && trigger_event) begin
            triggered_q <= 1'b1;
            if (post_len_q == ONE) begin
              state_q <= ST_DONE;
              we_q    <= 1'b0;
            end else begin
              state_q    <= ST_POST;
              post_rem_q <= post_len_q - ONE;
            end
          end
        end
        ST_POST: begin
          if (sample_tick && post_rem_q != '0) begin
            post_rem_q <= post_rem_q - ONE;
            if (post_rem_q == ONE) begin
              state_q <= ST_DONE;
              we_q    <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign status_byte_d = pack_status(state_q == ST_DONE, triggered_q, state_q);

  status_tx_reg u_status_tx_reg (
    .clk    (clk),
    .rst    (rst),
    .rqst_i (rqst_status),
    .ack_i  (status_ack),
    .data_i (status_byte_d),
    .data_o (status_data),
    .rdy_o  (status_rdy),
    .eof_o  (status_eof)
  );

  assign we            = we_q;
  assign num_samples_o = num_work_q;

endmodule

// File: tb/tb_acquisition_controller.sv
// Self-checking bench for acquisition_controller: directed scenarios plus
// randomized captures compared against a sample-counting reference model.
module tb_acquisition_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0, sample_tick = 1'b0, trigger_event = 1'b0;
  logic [7:0]  register_addr = 8'h00;
  logic [15:0] register_data = 16'h0000;
  logic        register_rdy = 1'b0, rqst_status = 1'b0, status_ack = 1'b0;
  logic        we, status_rdy, status_eof;
  logic [15:0] num_samples_o;
  logic [7:0]  status_data;

  int n_tests = 0;
  int n_fail  = 0;

  acquisition_controller dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .sample_tick   (sample_tick),
    .trigger_event (trigger_event),
    .register_addr (register_addr),
    .register_data (register_data),
    .register_rdy  (register_rdy),
    .rqst_status   (rqst_status),
    .we            (we),
    .num_samples_o (num_samples_o),
    .status_data   (status_data),
    .status_rdy    (status_rdy),
    .status_eof    (status_eof),
    .status_ack    (status_ack)
  );

  always #5 clk = ~clk;

  // Reference model: phase numbers follow the documented state codes; progress
  // is tracked as counts of samples seen in each phase.
  int          m_state, m_pre_seen, m_post_seen, m_P, m_N, m_reg_p, m_reg_n;
  bit          m_trig, m_we, m_srdy;
  logic [7:0]  m_sdata;
  logic [15:0] m_nout;
  int          we_ticks;

  task automatic step();
    logic [7:0] cur;
    int nN, nP;
    if (we && sample_tick) we_ticks++;
    @(posedge clk);
    if (!rst) begin
      m_state = 0; m_trig = 0; m_srdy = 0; m_sdata = 8'h00;
      m_reg_p = 128; m_reg_n = 256; m_nout = 16'd256;
      m_pre_seen = 0; m_post_seen = 0;
    end else begin
      cur = {m_state == 4, m_trig, 3'(m_state), 3'b000};
      if (m_srdy) begin
        if (status_ack) m_srdy = 0;
      end else if (rqst_status) begin
        m_srdy = 1; m_sdata = cur;
      end
      nN = (m_reg_n == 0) ? 1 : m_reg_n;
      nP = (m_reg_p < nN) ? m_reg_p : nN - 1;
      if (stop) begin
        m_state = 0; m_trig = 0;
      end else begin
        case (m_state)
          0, 4: if (start) begin
            m_state = 1; m_trig = 0; m_N = nN; m_P = nP; m_nout = 16'(nN);
            m_pre_seen = 0; m_post_seen = 0;
          end
          1: if (m_pre_seen >= m_P) m_state = 2;
             else if (sample_tick) begin
               m_pre_seen++;
               if (m_pre_seen == m_P) m_state = 2;
             end
          2: if (sample_tick && trigger_event) begin
               m_trig = 1; m_post_seen = 1;
               m_state = (m_post_seen == m_N - m_P) ? 4 : 3;
             end
          3: if (sample_tick) begin
               m_post_seen++;
               if (m_post_seen == m_N - m_P) m_state = 4;
             end
          default: ;
        endcase
      end
      if (register_rdy) begin
        if (register_addr == 8'h0B) m_reg_p = int'(register_data);
        if (register_addr == 8'h0C) m_reg_n = int'(register_data);
      end
    end
    m_we = (m_state >= 1 && m_state <= 3);
    #1;
  endtask

  function automatic logic [26:0] obs_vec();
    return {we, status_rdy, status_eof, status_data, num_samples_o};
  endfunction

  function automatic logic [26:0] exp_vec();
    return {m_we, m_srdy, m_srdy, m_sdata, m_nout};
  endfunction

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    register_addr = a; register_data = d; register_rdy = 1'b1;
    step();
    register_rdy = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; step(); step(); rst = 1'b1;
    n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", we); end
    n_tests++; if ({status_rdy, status_eof} !== 2'b00) begin n_fail++; $display("FAIL reset_status_rdy got=%b exp=00", {status_rdy, status_eof}); end
    n_tests++; if (status_data !== 8'h00) begin n_fail++; $display("FAIL reset_status_data got=%h exp=00", status_data); end
    n_tests++; if (num_samples_o !== 16'd256) begin n_fail++; $display("FAIL reset_num_samples got=%0d exp=256", num_samples_o); end
  endtask

  // Defaults P=128 N=256, tick every 4 cycles, trigger on tick 200.
  task automatic test_default_capture();
    int tidx = 0;
    int c = 0;
    pulse_start();
    we_ticks = 0;
    while (m_state != 4 && c < 3000) begin
      sample_tick = (c % 4 == 3);
      if (sample_tick) trigger_event = (tidx + 1 <= 128) ? 1'($urandom_range(0, 1)) : (tidx + 1 == 200);
      else trigger_event = 1'($urandom_range(0, 1));
      step();
      if (sample_tick) tidx++;
      n_tests++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL default_cycle c=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
      c++;
    end
    sample_tick = 1'b0; trigger_event = 1'b0;
    n_tests++; if (m_state != 4) begin n_fail++; $display("FAIL default_timeout got_state=%0d exp=4", m_state); end
    n_tests++; if (we_ticks !== 200 + (256 - 128) - 1) begin n_fail++; $display("FAIL default_we_ticks got=%0d exp=%0d", we_ticks, 200 + 128 - 1); end
    rqst_status = 1'b1; step(); rqst_status = 1'b0;
    n_tests++; if (status_data !== 8'hE0 || status_rdy !== 1'b1) begin n_fail++; $display("FAIL default_done_status got=%h/%b exp=e0/1", status_data, status_rdy); end
    status_ack = 1'b1; step(); status_ack = 1'b0;
  endtask

  task automatic test_p0_n1();
    wr(8'h0B, 16'd0); wr(8'h0C, 16'd1);
    pulse_start();
    n_tests++; if (we !== 1'b1 || num_samples_o !== 16'd1) begin n_fail++; $display("FAIL p0n1_pre got=%b/%0d exp=1/1", we, num_samples_o); end
    rqst_status = 1'b1; step(); rqst_status = 1'b0;
    n_tests++; if (status_data !== 8'h08) begin n_fail++; $display("FAIL p0n1_pre_status got=%h exp=08", status_data); end
    status_ack = 1'b1; step(); status_ack = 1'b0;
    rqst_status = 1'b1; step(); rqst_status = 1'b0;
    n_tests++; if (status_data !== 8'h10) begin n_fail++; $display("FAIL p0n1_armed_status got=%h exp=10", status_data); end
    status_ack = 1'b1; sample_tick = 1'b1; trigger_event = 1'b1; step();
    status_ack = 1'b0; sample_tick = 1'b0; trigger_event = 1'b0;
    n_tests++; if (we !== 1'b0 || m_state != 4) begin n_fail++; $display("FAIL p0n1_done_we got=%b exp=0", we); end
    rqst_status = 1'b1; step(); rqst_status = 1'b0;
    n_tests++; if (status_data !== 8'hE0) begin n_fail++; $display("FAIL p0n1_done_status got=%h exp=e0", status_data); end
    status_ack = 1'b1; step(); status_ack = 1'b0;
  endtask

  task automatic test_clamp();
    int tidx = 0;
    int c = 0;
    wr(8'h0B, 16'd300); wr(8'h0C, 16'd100);
    pulse_start();
    we_ticks = 0;
    n_tests++; if (num_samples_o !== 16'd100) begin n_fail++; $display("FAIL clamp_num_samples got=%0d exp=100", num_samples_o); end
    while (m_state != 4 && c < 1000) begin
      sample_tick = (c % 2 == 1);
      trigger_event = sample_tick && (tidx + 1 == 105);
      step();
      if (sample_tick) tidx++;
      n_tests++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL clamp_cycle c=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
      c++;
    end
    sample_tick = 1'b0; trigger_event = 1'b0;
    n_tests++; if (tidx != 105 || we !== 1'b0) begin n_fail++; $display("FAIL clamp_done_tick got=%0d/%b exp=105/0", tidx, we); end
    n_tests++; if (we_ticks !== 105) begin n_fail++; $display("FAIL clamp_we_ticks got=%0d exp=105", we_ticks); end
  endtask

  // Brings a P=2, N=10 capture into POST (trigger on tick 3).
  task automatic run_to_post();
    wr(8'h0B, 16'd2); wr(8'h0C, 16'd10);
    pulse_start();
    sample_tick = 1'b1;
    step(); step();
    trigger_event = 1'b1; step();
    sample_tick = 1'b0; trigger_event = 1'b0;
  endtask

  task automatic test_stop_start();
    wr(8'h0B, 16'd1); wr(8'h0C, 16'd5);
    pulse_start();
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
    n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL stopstart_we got=%b exp=0", we); end
    rqst_status = 1'b1; step(); rqst_status = 1'b0;
    n_tests++; if (status_data !== 8'h00) begin n_fail++; $display("FAIL stopstart_status got=%h exp=00", status_data); end
    status_ack = 1'b1; step(); status_ack = 1'b0;
    run_to_post();
    stop = 1'b1; step(); stop = 1'b0;
    rqst_status = 1'b1; step(); rqst_status = 1'b0;
    n_tests++; if (status_data !== 8'h00 || we !== 1'b0) begin n_fail++; $display("FAIL stop_post_status got=%h/%b exp=00/0", status_data, we); end
    status_ack = 1'b1; step(); status_ack = 1'b0;
  endtask

  task automatic test_status_hold();
    run_to_post();
    rqst_status = 1'b1; step(); rqst_status = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stop = (i == 1);
      rqst_status = (i == 3);
      n_tests++; if ({status_rdy, status_eof, status_data} !== {2'b11, 8'h58}) begin n_fail++; $display("FAIL status_hold i=%0d got=%b%b/%h exp=11/58", i, status_rdy, status_eof, status_data); end
      step();
    end
    stop = 1'b0; rqst_status = 1'b0;
    n_tests++; if ({status_rdy, status_data} !== {1'b1, 8'h58}) begin n_fail++; $display("FAIL status_ack_cycle got=%b/%h exp=1/58", status_rdy, status_data); end
    status_ack = 1'b1; step(); status_ack = 1'b0;
    n_tests++; if ({status_rdy, status_eof} !== 2'b00) begin n_fail++; $display("FAIL status_drop got=%b%b exp=00", status_rdy, status_eof); end
  endtask

  task automatic test_reset_mid();
    run_to_post();
    rqst_status = 1'b1; rst = 1'b0; step(); rqst_status = 1'b0; rst = 1'b1;
    n_tests++; if ({we, status_rdy, status_eof, status_data, num_samples_o} !== {3'b000, 8'h00, 16'd256}) begin n_fail++; $display("FAIL reset_mid got=%h exp=%h", obs_vec(), {3'b000, 8'h00, 16'd256}); end
    sample_tick = 1'b1; trigger_event = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_we i=%0d got=%b exp=0", i, we); end
    end
    sample_tick = 1'b0; trigger_event = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      wr(8'h0B, 16'($urandom_range(0, 12)));
      wr(8'h0C, 16'($urandom_range(0, 20)));
      wr(8'h0D, 16'($urandom_range(0, 65535)));
      pulse_start();
      for (int c = 0; c < 300; c++) begin
        sample_tick   = ($urandom_range(0, 2) == 0);
        trigger_event = ($urandom_range(0, 3) == 0);
        rqst_status   = ($urandom_range(0, 5) == 0);
        status_ack    = ($urandom_range(0, 2) == 0);
        stop          = ($urandom_range(0, 149) == 0);
        start         = ($urandom_range(0, 39) == 0);
        step();
        n_tests++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL random_cycle it=%0d c=%0d got=%h exp=%h", it, c, obs_vec(), exp_vec()); end
      end
      {sample_tick, trigger_event, rqst_status, status_ack, stop, start} = 6'b0;
      stop = 1'b1; step(); stop = 1'b0;
      status_ack = 1'b1; step(); status_ack = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_default_capture();
    test_p0_n1();
    test_clamp();
    test_stop_start();
    test_status_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
